// File: rtl/morse_pkg.sv
// Purpose : shared morse constants: FSM encoding, letter codes S..Z, element values, decode lookup.
// Latency : n/a (types, constants and a combinational function only).
// Backpressure: n/a.
// Contents: state_t, LTR_S..LTR_Z, ELEM_DOT/ELEM_DASH, run-length thresholds, lookup_t, morse_lookup().
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // 3-bit letter codes, identical to the flasher's SW[2:0] pattern index
  localparam logic [2:0] LTR_S = 3'b000;
  localparam logic [2:0] LTR_T = 3'b001;
  localparam logic [2:0] LTR_U = 3'b010;
  localparam logic [2:0] LTR_V = 3'b011;
  localparam logic [2:0] LTR_W = 3'b100;
  localparam logic [2:0] LTR_X = 3'b101;
  localparam logic [2:0] LTR_Y = 3'b110;
  localparam logic [2:0] LTR_Z = 3'b111;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  // run lengths measured in sampled units
  localparam logic [2:0] RUN_DOT    = 3'd1;
  localparam logic [2:0] RUN_DASH   = 3'd3;
  localparam logic [2:0] RUN_SAT    = 3'd4;
  localparam logic [2:0] GAP_LETTER = 3'd3;
  localparam logic [2:0] QUIET_RUNS = 3'd3;
  localparam logic [2:0] MAX_ELEMS  = 3'd4;

  typedef struct packed {
    logic       err;
    logic [2:0] letter;
  } lookup_t;

  // Elements are shifted in at the LSB, so the last element sent sits in bit 0
  // and unused upper bits stay zero.
  function automatic lookup_t morse_lookup(input logic [2:0] cnt, input logic [3:0] bits);
    lookup_t res;
    res.err    = 1'b0;
    res.letter = LTR_S;
    case ({cnt, bits})
      {3'd1, 4'b0001}: res.letter = LTR_T;
      {3'd3, 4'b0000}: res.letter = LTR_S;
      {3'd3, 4'b0001}: res.letter = LTR_U;
      {3'd3, 4'b0011}: res.letter = LTR_W;
      {3'd4, 4'b0001}: res.letter = LTR_V;
      {3'd4, 4'b1001}: res.letter = LTR_X;
      {3'd4, 4'b1011}: res.letter = LTR_Y;
      {3'd4, 4'b1100}: res.letter = LTR_Z;
      default:         res.err    = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Purpose : morse unit sample timer; a load re-phases it so ticks fall mid-unit, held while idle.
// Latency : first tick UNIT_CYCLES/2 cycles after load, then one tick every UNIT_CYCLES cycles.
// Backpressure: none; tick is a free-running one-cycle strobe.
// Ports: CLOCK_50/reset (sync, active-high), load (resync to half unit), run (count enable), tick (sample strobe).
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  // UNIT_CYCLES must be even and >= 4 so the half-unit load is a positive count.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(UNIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] WRAP_LOAD = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = HALF_LOAD;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? WRAP_LOAD : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/morse_decoder.sv
// Purpose : decodes a serial morse line (letters S..Z) back to the 3-bit flasher code, flags bad symbols.
// Latency : first sample 2+UNIT_CYCLES/2 cycles after a mark edge; result pulses the cycle after the 3rd gap sample.
// Backpressure: none; letter_valid/letter_err are one-cycle strobes that must be consumed when seen.
// Ports: CLOCK_50, reset (sync, active-high), sym_in (async line), letter[2:0] (held),
//        letter_valid / letter_err (one-cycle pulses, never together), busy (FSM not idle).
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sym_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy
);

  logic       sync_q, sync_d;
  logic       sym_s_q, sym_s_d;
  logic       sym_prev_q, sym_prev_d;
  state_t     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic [3:0] elem_bits_q, elem_bits_d;
  logic [2:0] elem_cnt_q, elem_cnt_d;
  logic [2:0] letter_q, letter_d;
  logic       letter_valid_q, letter_valid_d;
  logic       letter_err_q, letter_err_d;

  logic       rise;
  logic       tick;
  lookup_t    lookup_res;

  assign rise = sym_s_q && !sym_prev_q;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (rise),
    .run      (state_q != ST_IDLE),
    .tick     (tick)
  );

  assign lookup_res = morse_lookup(elem_cnt_q, elem_bits_q);

  always_comb begin
    sync_d         = sym_in;
    sym_s_d        = sync_q;
    sym_prev_d     = sym_s_q;
    state_d        = state_q;
    run_d          = run_q;
    elem_bits_d    = elem_bits_q;
    elem_cnt_d     = elem_cnt_q;
    letter_d       = letter_q;
    letter_valid_d = 1'b0;
    letter_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_MARK;
          run_d       = 3'd0;
          elem_bits_d = 4'd0;
          elem_cnt_d  = 3'd0;
        end
      end

      ST_MARK: begin
        if (tick) begin
          if (sym_s_q) begin
            // saturate so a stuck-high line still resolves to ERR on its first low sample
            if (run_q != RUN_SAT) run_d = run_q + 3'd1;
          end else if ((run_q == RUN_DOT || run_q == RUN_DASH) && elem_cnt_q != MAX_ELEMS) begin
            elem_bits_d = {elem_bits_q[2:0], (run_q == RUN_DASH) ? ELEM_DASH : ELEM_DOT};
            elem_cnt_d  = elem_cnt_q + 3'd1;
            state_d     = ST_SPACE;
            run_d       = 3'd1;  // this low sample is the first gap unit
          end else begin
            state_d      = ST_ERR;
            run_d        = 3'd0;
            letter_err_d = 1'b1;
          end
        end
      end

      ST_SPACE: begin
        if (tick) begin
          if (sym_s_q) begin
            if (run_q == 3'd1) begin
              state_d = ST_MARK;
              run_d   = 3'd1;  // this high sample is the first unit of the next mark
            end else begin
              state_d      = ST_ERR;
              run_d        = 3'd0;
              letter_err_d = 1'b1;
            end
          end else begin
            run_d = run_q + 3'd1;
            if (run_q == GAP_LETTER - 3'd1) begin
              state_d = ST_IDLE;
              if (lookup_res.err) begin
                letter_err_d = 1'b1;
              end else begin
                letter_valid_d = 1'b1;
                letter_d       = lookup_res.letter;
              end
            end
          end
        end
      end

      ST_ERR: begin
        // run_q counts consecutive quiet samples here
        if (rise) begin
          run_d = 3'd0;
        end else if (tick) begin
          if (sym_s_q) begin
            run_d = 3'd0;
          end else if (run_q == QUIET_RUNS - 3'd1) begin
            state_d = ST_IDLE;
            run_d   = 3'd0;
          end else begin
            run_d = run_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q         <= 1'b0;
      sym_s_q        <= 1'b0;
      sym_prev_q     <= 1'b0;
      state_q        <= ST_IDLE;
      run_q          <= 3'd0;
      elem_bits_q    <= 4'd0;
      elem_cnt_q     <= 3'd0;
      letter_q       <= 3'd0;
      letter_valid_q <= 1'b0;
      letter_err_q   <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      sym_s_q        <= sym_s_d;
      sym_prev_q     <= sym_prev_d;
      state_q        <= state_d;
      run_q          <= run_d;
      elem_bits_q    <= elem_bits_d;
      elem_cnt_q     <= elem_cnt_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      letter_err_q   <= letter_err_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = letter_valid_q;
  assign letter_err   = letter_err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Purpose : self-checking bench for morse_decoder with a run-length reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_morse_decoder;

  localparam int UNIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sym_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;

  always #5 clk = ~clk;

  morse_decoder #(.UNIT_CYCLES(UNIT), .CNT_W(4)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .sym_in       (sym_in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_err   (letter_err),
    .busy         (busy)
  );

  typedef struct { bit is_err; int ltr; } ev_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  ev_t   obs_q[$];
  ev_t   exp_q[$];
  bit    stim_q[$];
  string morse_tab[8];
  int    m_last;
  int    both_hi   = 0;
  int    long_puls = 0;
  int    obs_valid, obs_err;
  ev_t   mon_e;
  logic  prev_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (letter_valid) begin
        mon_e.is_err = 1'b0; mon_e.ltr = int'(letter); obs_q.push_back(mon_e);
      end
      if (letter_err) begin
        mon_e.is_err = 1'b1; mon_e.ltr = int'(letter); obs_q.push_back(mon_e);
      end
      if (letter_valid && letter_err) both_hi++;
      if (prev_pulse && (letter_valid || letter_err)) long_puls++;
      prev_pulse = letter_valid || letter_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void add_level(input bit lv, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(lv);
  endfunction

  function automatic void add_vec(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(t[i]);
  endfunction

  function automatic void add_letter(input int k, input int gap);
    string s;
    s = morse_tab[k];
    for (int j = 0; j < s.len(); j++) begin
      add_level(1'b1, (s[j] == ".") ? 1 : 3);
      add_level(1'b0, (j == s.len() - 1) ? gap : 1);
    end
  endfunction

  task automatic add_random_word();
    int n, p, ln;
    add_level(1'b0, $urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) begin
      add_letter($urandom_range(0, 7), $urandom_range(3, 5));
    end else begin
      n = $urandom_range(1, 5);
      for (int e = 0; e < n; e++) begin
        p = $urandom_range(0, 9);
        if (p < 6)                          ln = 1;
        else if (p < 9)                     ln = 3;
        else if ($urandom_range(0, 2) == 0) ln = 2;
        else                                ln = 4 + $urandom_range(0, 3);
        add_level(1'b1, ln);
        if (e == n - 1)                     add_level(1'b0, $urandom_range(3, 5));
        else if ($urandom_range(0, 9) == 0) add_level(1'b0, 2);
        else                                add_level(1'b0, 1);
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_exp(input bit is_err, input int ltr);
    ev_t e;
    e.is_err = is_err;
    e.ltr    = ltr;
    exp_q.push_back(e);
  endfunction

  function automatic void model_emit(input string el);
    int found;
    found = -1;
    for (int k = 0; k < 8; k++) if (morse_tab[k] == el) found = k;
    if (found < 0) begin
      push_exp(1'b1, m_last);
    end else begin
      push_exp(1'b0, found);
      m_last = found;
    end
  endfunction

  // Splits the unit stream into runs of equal level and applies the timing
  // rules per run: mark 1/3 = dot/dash, gap 1 = next element, gap 2 then mark =
  // error, gap >= 3 = end of letter; after an error, three quiet units are needed.
  function automatic void model();
    int    lvl[$];
    int    len[$];
    int    mode, skip, r, l_m, g;
    string el;
    foreach (stim_q[i]) begin
      if (lvl.size() > 0 && lvl[lvl.size() - 1] == int'(stim_q[i])) len[len.size() - 1] += 1;
      else begin
        lvl.push_back(int'(stim_q[i]));
        len.push_back(1);
      end
    end
    mode = 0; skip = 0; r = 0; el = "";
    while (r < lvl.size()) begin
      if (mode == 0) begin
        if (lvl[r] == 1) begin mode = 1; el = ""; end
        else r++;
      end else if (mode == 1) begin
        l_m = len[r];
        r++;
        if (r >= lvl.size()) begin
          r = lvl.size();
        end else if ((l_m != 1 && l_m != 3) || el.len() == 4) begin
          push_exp(1'b1, m_last); mode = 2; skip = 1;
        end else begin
          if (l_m == 1) el = {el, "."};
          else          el = {el, "-"};
          g = len[r];
          r++;
          if (g >= 3) begin
            model_emit(el); mode = 0;
          end else if (g == 2 && r < lvl.size()) begin
            push_exp(1'b1, m_last); mode = 2; skip = 0;
          end
        end
      end else begin
        if (lvl[r] == 0 && len[r] - skip >= 3) mode = 0;
        skip = 0;
        r++;
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_stim();
    foreach (stim_q[i]) begin
      sym_in = stim_q[i];
      repeat (UNIT) @(posedge clk);
      #1;
    end
    stim_q.delete();
  endtask

  task automatic run_stream(input string tag);
    add_level(1'b0, 6);
    exp_q.delete();
    model();
    obs_q.delete();
    drive_stim();
    repeat (2) @(posedge clk);
    #1;
    obs_valid = 0; obs_err = 0;
    foreach (obs_q[i]) if (obs_q[i].is_err) obs_err++; else obs_valid++;
    chk({tag, "_nevents"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].is_err, exp_q[i].is_err);
      chk($sformatf("%s_ev%0d_letter", tag, i), obs_q[i].ltr, exp_q[i].ltr);
    end
    chk({tag, "_held_letter"}, letter, m_last);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    morse_tab[0] = "...";  morse_tab[1] = "-";    morse_tab[2] = "..-";  morse_tab[3] = "...-";
    morse_tab[4] = ".--";  morse_tab[5] = "-..-"; morse_tab[6] = "-.--"; morse_tab[7] = "--..";
    m_last = 0;
    reset  = 1'b1;
    sym_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_letter", letter, 0);
    chk("rst_valid", letter_valid, 0);
    chk("rst_err", letter_err, 0);
    chk("rst_busy", busy, 0);

    // S
    add_vec(32'b10101000000000, 14);
    run_stream("t1_S");
    chk("t1_valid_cnt", obs_valid, 1);
    chk("t1_err_cnt", obs_err, 0);
    chk("t1_letter", letter, 3'b000);

    // Z then T
    add_vec(32'b11101110101000, 14);
    run_stream("t2_Z");
    chk("t2_Z_letter", letter, 3'b111);
    add_vec(32'b11100000000000, 14);
    run_stream("t2_T");
    chk("t2_T_letter", letter, 3'b001);

    // all eight letters back to back with minimum letter gap
    for (int k = 0; k < 8; k++) add_letter(k, 3);
    run_stream("t3_all");
    chk("t3_valid_cnt", obs_valid, 8);
    for (int i = 0; i < obs_q.size() && i < 8; i++) chk($sformatf("t3_order%0d", i), obs_q[i].ltr, i);

    // mark run of 2 units
    add_vec(32'b110000, 6);
    run_stream("t4_run2");
    chk("t4_err_cnt", obs_err, 1);
    chk("t4_valid_cnt", obs_valid, 0);
    chk("t4_letter_kept", letter, 3'b111);

    // five dots, then H (unmapped)
    add_vec(32'b1010101010000, 13);
    run_stream("t5_5dots");
    chk("t5_5dots_err", obs_err, 1);
    add_vec(32'b1010101000, 10);
    run_stream("t5_H");
    chk("t5_H_err", obs_err, 1);

    // line stuck high
    add_level(1'b1, 12);
    run_stream("t5_stuck");
    chk("t5_stuck_err", obs_err, 1);

    // reset in the middle of U, then a full U
    add_vec(32'b1010, 4);
    drive_stim();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_last = 0;
    chk("t6_letter", letter, 0);
    chk("t6_valid", letter_valid, 0);
    chk("t6_err", letter_err, 0);
    chk("t6_busy", busy, 0);
    add_level(1'b0, 3);
    drive_stim();
    add_vec(32'b1010111000, 10);
    run_stream("t6_U");
    chk("t6_U_letter", letter, 3'b010);

    // randomized words
    for (int s = 0; s < 25; s++) begin
      for (int w = 0; w < 3; w++) add_random_word();
      run_stream($sformatf("rnd%0d", s));
    end

    chk("pulses_overlap", both_hi, 0);
    chk("pulse_width", long_puls, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
